// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the AXI-Stream S2MM packetizer.
// Holds the FIFO entry layout, the counter width and the saturating increment.
package axis_pkt_pkg;

   localparam int CNT_W       = 32;
   localparam int AXIS_DATA_W = 64;   // widest supported DATA_W

   typedef struct packed {
      logic                   tlast;
      logic [AXIS_DATA_W-1:0] tdata;
   } fifo_entry_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/axis_pkt_fifo.sv
// Synchronous FIFO of fifo_entry_t with registered head; write->rd_vld 1 cycle.
// Backpressure: writes are ignored when full; head is held stable until rd_en.
module axis_pkt_fifo
   import axis_pkt_pkg::*;
#(
   parameter int DEPTH = 512
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  fifo_entry_t wr_entry,
   input  logic        rd_en,
   output fifo_entry_t rd_entry,
   output logic        rd_vld,
   output logic        full,
   output logic        empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         rd_vld_q, rd_vld_d;
   fifo_entry_t  rd_entry_q, rd_entry_d;
   fifo_entry_t  mem_q [DEPTH];
   logic         wr_ok;
   logic         pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      wr_ok    = wr_en & ~full;
      pop      = rd_vld_q & rd_en;
      wr_ptr_d = wr_ptr_q + (AW+1)'(wr_ok);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
      rd_vld_d = (wr_ptr_d != rd_ptr_d);
      // The entry being written this cycle may become the new head: bypass it.
      if (wr_ok && (wr_ptr_q == rd_ptr_d)) begin
         rd_entry_d = wr_entry;
      end else begin
         rd_entry_d = mem_q[rd_ptr_d[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_vld_q   <= 1'b0;
         rd_entry_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_vld_q   <= rd_vld_d;
         rd_entry_q <= rd_entry_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
      end
   end

   assign rd_entry = rd_entry_q;
   assign rd_vld   = rd_vld_q;

endmodule

// File: rtl/axis_s2mm_packetizer.sv
// Frames a free-running sample stream into fixed-length AXI-Stream packets; last beat reaches the FIFO 1 cycle after accept, tvalid 1 cycle later.
// No input backpressure: on a full FIFO incoming beats are dropped and counted. AXIS_PKT_TIMEOUT_EN enables the idle-timeout close.
module axis_s2mm_packetizer
   import axis_pkt_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 512,
   parameter int LEN_W      = 16,
   parameter int TIMEOUT_W  = 16
) (
   input  logic                 axis_clk,
   input  logic                 axi_rst_n,
   input  logic                 enable,
   input  logic [LEN_W-1:0]     pkt_len,
   input  logic [TIMEOUT_W-1:0] timeout,
   input  logic [DATA_W-1:0]    s_data,
   input  logic                 s_valid,
   output logic [DATA_W-1:0]    m_axis_tdata,
   output logic [DATA_W/8-1:0]  m_axis_tkeep,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 busy,
   output logic [CNT_W-1:0]     overflow_cnt,
   output logic [CNT_W-1:0]     pkt_cnt
);

   logic                enable_q;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic                hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0]   hold_data_q, hold_data_d;
   logic                hold_last_q, hold_last_d;
   logic [CNT_W-1:0]    overflow_cnt_q, overflow_cnt_d;
   logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;

   logic [LEN_W-1:0]    eff_len, last_idx, base_cnt;
   logic                accept_in, accept, flush, to_fire;
   logic                wr_req, wr_en, stall;
   logic                fifo_full, fifo_empty, fifo_vld;
   fifo_entry_t         wr_entry, rd_entry;

`ifdef AXIS_PKT_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic                 to_pend_q, to_pend_d;

   // Fire gating uses the raw input beat so the flush path stays free of FIFO-full feedback.
   always_comb begin
      to_fire = to_pend_q |
                (hold_valid_q & enable & ~accept_in & (timeout != '0) &
                 ((idle_cnt_q + TIMEOUT_W'(1)) == timeout));
      to_pend_d  = to_fire & ~wr_en;
      idle_cnt_d = idle_cnt_q;
      if (accept) begin
         idle_cnt_d = '0;
      end else if (hold_valid_q && enable && (idle_cnt_q != '1)) begin
         idle_cnt_d = idle_cnt_q + TIMEOUT_W'(1);
      end
   end

   always_ff @(posedge axis_clk) begin
      if (!axi_rst_n) begin
         idle_cnt_q <= '0;
         to_pend_q  <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         to_pend_q  <= to_pend_d;
      end
   end
`else
   logic timeout_unused;
   assign timeout_unused = ^timeout;
   assign to_fire        = 1'b0;
`endif

   always_comb begin
      len_d = len_q;
      if (enable && !enable_q && (beat_cnt_q == '0)) begin
         len_d = pkt_len;
      end
      eff_len  = (len_d == '0) ? LEN_W'(1) : len_d;
      last_idx = eff_len - LEN_W'(1);

      accept_in = enable & s_valid;
      flush     = hold_valid_q & (~enable | to_fire);
      wr_req    = hold_valid_q & (accept_in | hold_last_q | flush);
      stall     = wr_req & fifo_full;
      wr_en     = wr_req & ~fifo_full;
      accept    = accept_in & ~stall;

      wr_entry                    = '0;
      wr_entry.tlast              = hold_last_q | flush;
      wr_entry.tdata[DATA_W-1:0]  = hold_data_q;

      hold_valid_d = hold_valid_q & ~wr_en;
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      // A flush closes the held packet, so a beat arriving alongside it starts a new one.
      base_cnt     = (wr_en && flush) ? '0 : beat_cnt_q;
      beat_cnt_d   = base_cnt;
      if (accept) begin
         hold_valid_d = 1'b1;
         hold_data_d  = s_data;
         hold_last_d  = (base_cnt == last_idx);
         beat_cnt_d   = (base_cnt == last_idx) ? '0 : base_cnt + LEN_W'(1);
      end

      overflow_cnt_d = (accept_in && stall) ? sat_inc(overflow_cnt_q) : overflow_cnt_q;
      pkt_cnt_d      = pkt_cnt_q +
                       CNT_W'(fifo_vld & m_axis_tready & rd_entry.tlast);
   end

   always_ff @(posedge axis_clk) begin
      if (!axi_rst_n) begin
         enable_q       <= 1'b0;
         len_q          <= '0;
         beat_cnt_q     <= '0;
         hold_valid_q   <= 1'b0;
         hold_data_q    <= '0;
         hold_last_q    <= 1'b0;
         overflow_cnt_q <= '0;
         pkt_cnt_q      <= '0;
      end else begin
         enable_q       <= enable;
         len_q          <= len_d;
         beat_cnt_q     <= beat_cnt_d;
         hold_valid_q   <= hold_valid_d;
         hold_data_q    <= hold_data_d;
         hold_last_q    <= hold_last_d;
         overflow_cnt_q <= overflow_cnt_d;
         pkt_cnt_q      <= pkt_cnt_d;
      end
   end

   axis_pkt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (axis_clk),
      .rst_n    (axi_rst_n),
      .wr_en    (wr_en),
      .wr_entry (wr_entry),
      .rd_en    (m_axis_tready),
      .rd_entry (rd_entry),
      .rd_vld   (fifo_vld),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign m_axis_tdata  = rd_entry.tdata[DATA_W-1:0];
   assign m_axis_tlast  = rd_entry.tlast;
   assign m_axis_tvalid = fifo_vld;
   assign m_axis_tkeep  = '1;
   assign busy          = hold_valid_q | ~fifo_empty;
   assign overflow_cnt  = overflow_cnt_q;
   assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_axis_s2mm_packetizer.sv
// Directed bench for axis_s2mm_packetizer; expected beats are queued as stimulus is driven
// and popped when the DUT completes a handshake on m_axis.
module tb_axis_s2mm_packetizer;

   localparam int DATA_W     = 64;
   localparam int FIFO_DEPTH = 16;
   localparam int LEN_W      = 16;
   localparam int TIMEOUT_W  = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 enable;
   logic [LEN_W-1:0]     pkt_len;
   logic [TIMEOUT_W-1:0] timeout;
   logic [DATA_W-1:0]    s_data;
   logic                 s_valid;
   logic [DATA_W-1:0]    m_axis_tdata;
   logic [DATA_W/8-1:0]  m_axis_tkeep;
   logic                 m_axis_tvalid;
   logic                 m_axis_tready;
   logic                 m_axis_tlast;
   logic                 busy;
   logic [31:0]          overflow_cnt;
   logic [31:0]          pkt_cnt;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic              l;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   axis_s2mm_packetizer #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .LEN_W      (LEN_W),
      .TIMEOUT_W  (TIMEOUT_W)
   ) dut (
      .axis_clk      (clk),
      .axi_rst_n     (rst_n),
      .enable        (enable),
      .pkt_len       (pkt_len),
      .timeout       (timeout),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy),
      .overflow_cnt  (overflow_cnt),
      .pkt_cnt       (pkt_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push(input logic [DATA_W-1:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      sb.push_back(e);
   endfunction

   // n beats from base; tlast every len beats, and on the final beat if close is set.
   function automatic void exp_pkt(input int n, input int base, input int len, input bit close);
      for (int i = 0; i < n; i++) begin
         push(DATA_W'(base + i), (((i + 1) % len) == 0) || (close && (i == n - 1)));
      end
   endfunction

   task automatic send(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = DATA_W'(base + i);
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || m_axis_tvalid) && (n < 200)) begin
         tick();
         n++;
      end
      check({tag, "_drained"}, 64'(busy | m_axis_tvalid), 64'd0);
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic rearm(input logic [LEN_W-1:0] len);
      enable  = 1'b0;
      tick();
      pkt_len = len;
      enable  = 1'b1;
   endtask

   // Scoreboard consumer: compares every completed output handshake.
   always @(negedge clk) begin
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
         if (sb.size() == 0) begin
            check("unexpected_beat", m_axis_tdata, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("beat_tdata", m_axis_tdata, e.d);
            check("beat_tlast", 64'(m_axis_tlast), 64'(e.l));
            check("beat_tkeep", 64'(m_axis_tkeep), 64'hFF);
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      enable        = 1'b0;
      pkt_len       = '0;
      timeout       = '0;
      s_data        = '0;
      s_valid       = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) tick();

      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_tdata", m_axis_tdata, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ovf", 64'(overflow_cnt), 64'd0);
      check("rst_pkt", 64'(pkt_cnt), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic framing: two 4-beat packets at full rate.
      m_axis_tready = 1'b1;
      pkt_len       = 16'd4;
      enable        = 1'b1;
      exp_pkt(8, 0, 4, 1'b0);
      send(8, 0);
      wait_idle("basic");
      check("basic_pkt_cnt", 64'(pkt_cnt), 64'd2);
      check("basic_ovf", 64'(overflow_cnt), 64'd0);

      // Disable closes a 5-of-8 partial packet.
      rearm(16'd8);
      exp_pkt(5, 100, 8, 1'b1);
      send(5, 100);
      enable = 1'b0;
      wait_idle("disable");
      check("disable_pkt_cnt", 64'(pkt_cnt), 64'd3);

      // Length 1 and length 0 both give single-beat packets.
      rearm(16'd1);
      exp_pkt(3, 200, 1, 1'b0);
      send(3, 200);
      wait_idle("len1");
      check("len1_pkt_cnt", 64'(pkt_cnt), 64'd6);
      rearm(16'd0);
      exp_pkt(3, 300, 1, 1'b0);
      send(3, 300);
      wait_idle("len0");
      check("len0_pkt_cnt", 64'(pkt_cnt), 64'd9);

      // Overflow: 16 queued, 1 held, 3 dropped.
      m_axis_tready = 1'b0;
      rearm(16'd64);
      exp_pkt(16, 400, 64, 1'b0);
      send(20, 400);
      tick();
      check("ovf_cnt", 64'(overflow_cnt), 64'd3);
      check("ovf_busy", 64'(busy), 64'd1);
      check("ovf_tvalid_held", 64'(m_axis_tvalid), 64'd1);
      check("ovf_head_stable", m_axis_tdata, 64'd400);
      m_axis_tready = 1'b1;
      begin
         int n = 0;
         while (m_axis_tvalid && (n < 100)) begin
            tick();
            n++;
         end
         check("ovf_drain", 64'(m_axis_tvalid), 64'd0);
      end
      check("ovf_hold_busy", 64'(busy), 64'd1);
      push(DATA_W'(416), 1'b1);
      enable = 1'b0;
      wait_idle("ovf");
      check("ovf_pkt_cnt", 64'(pkt_cnt), 64'd10);
      check("ovf_cnt_kept", 64'(overflow_cnt), 64'd3);

      // Idle timeout of 10 cycles after 3 of 8 beats.
      timeout = 16'd10;
      rearm(16'd8);
`ifdef AXIS_PKT_TIMEOUT_EN
      exp_pkt(3, 500, 8, 1'b1);
      send(3, 500);
      repeat (9) tick();
      check("to_not_yet", 64'(m_axis_tvalid), 64'd0);
      tick();
      check("to_tvalid", 64'(m_axis_tvalid), 64'd1);
      check("to_tlast", 64'(m_axis_tlast), 64'd1);
      check("to_tdata", m_axis_tdata, 64'd502);
      wait_idle("timeout");
      enable = 1'b0;
`else
      exp_pkt(2, 500, 8, 1'b0);
      send(3, 500);
      repeat (30) tick();
      check("noto_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("noto_busy", 64'(busy), 64'd1);
      push(DATA_W'(502), 1'b1);
      enable = 1'b0;
      wait_idle("notimeout");
`endif
      check("to_pkt_cnt", 64'(pkt_cnt), 64'd11);
      timeout = '0;

      // Reset mid-packet discards queued beats; next packet is complete.
      m_axis_tready = 1'b0;
      rearm(16'd8);
      send(3, 600);
      tick();
      rst_n = 1'b0;
      tick();
      check("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("mrst_pkt", 64'(pkt_cnt), 64'd0);
      check("mrst_ovf", 64'(overflow_cnt), 64'd0);
      check("mrst_busy", 64'(busy), 64'd0);
      rst_n         = 1'b1;
      m_axis_tready = 1'b1;
      exp_pkt(8, 700, 8, 1'b0);
      send(8, 700);
      wait_idle("post_rst");
      check("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd1);
      enable = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axis_s2mm_packetizer.md
# axis_s2mm_packetizer

Frames a free-running sample stream (ADC or processing output, no backpressure) into fixed-length AXI-Stream packets with `tlast`, buffered in a FIFO, for the DMA S2MM slave stream. Sits directly upstream of the DMA write channel in the shell. It absorbs DMA stalls, drops and counts samples on overflow, and closes partial packets on disable or on idle timeout.

## Interface
- `DATA_W`, 64, sample/stream width in bits; a multiple of 8.
- `FIFO_DEPTH`, 512, FIFO entries; a power of 2, at least 4.
- `LEN_W`, 16, width of the packet-length field.
- `TIMEOUT_W`, 16, width of the idle-timeout field.

Ports:
- `axis_clk`  in  1  single clock for the whole block.
- `axi_rst_n`  in  1  reset; synchronous, active-low.
- `enable`  in  1  capture enable.
- `pkt_len`  in  LEN_W  packet length in beats. Value 0 is treated as 1.
- `timeout`  in  TIMEOUT_W  idle cycles before a partial packet is closed. Value 0 disables the timeout.
- `s_data`  in  DATA_W  input sample.
- `s_valid`  in  1  input sample valid. There is no ready; the source never stalls.
- `m_axis`  master  `axis` interface to the DMA S2MM stream (`tdata` DATA_W, `tkeep` DATA_W/8, `tvalid`, `tready`, `tlast`).
- `busy`  out  1  high while a beat is held, queued, or in flight.
- `overflow_cnt`  out  32  dropped input beats; saturates at 0xFFFF_FFFF.
- `pkt_cnt`  out  32  packets completed on `m_axis`; wraps.

## Operation
- `len_q` is latched from `pkt_len` on the rising edge of `enable`, but only when `beat_cnt == 0`. Otherwise the previous value is kept.
- An input beat is accepted when `enable & s_valid` and it is not dropped. `beat_cnt` increments on each accepted beat.
- One-entry hold stage (`hold_valid`, `hold_data`, `hold_last`):
  - An accepted beat always enters the hold stage.
  - `hold_last` is set when `beat_cnt == len_q-1`; `beat_cnt` then returns to 0.
- FIFO write: `wr = hold_valid & (accept | hold_last | flush)`.
  - The written `tlast` is `hold_last | flush`.
  - At most one write per cycle.
  - A held beat and a new accept in the same cycle: the held beat is written and the new beat enters the hold stage.
- `flush` is asserted when either of these occurs while `hold_valid` is high:
  - `enable` is low (falling edge, or any later cycle);
  - the timeout fires.
  
  A flush closes the packet and clears `beat_cnt`.
- Overflow: if `wr` is required and the FIFO is full, nothing is written, the hold contents are kept, any incoming beat is dropped, and `overflow_cnt` increments. A pending flush stays pending until space frees.
- Output side:
  - `m_axis.tdata/tlast` come from the FIFO head.
  - `tvalid` stays high until `tready`, and data stays stable meanwhile.
  - `tkeep` is all ones.
- `pkt_cnt` increments on `tvalid & tready & tlast`.
- `busy = hold_valid | ~fifo_empty`.

## Timing
- After reset, every output is 0 (`m_axis.tvalid`, `tlast`, `tdata`, `busy`, both counters); the FIFO and hold stage are empty and `beat_cnt = 0`.
- Latency from input to FIFO:
  - the last beat of a packet is written 1 cycle after acceptance;
  - other beats are written when the next beat arrives.
- FIFO write to `m_axis.tvalid`: 1 cycle (registered output).
- Full throughput: 1 beat per cycle when `tready` is held high.
- Reset mid-packet clears all state on the next edge. A partial packet is discarded; no `tlast` is emitted for it.

## Configuration
- `AXIS_PKT_TIMEOUT_EN` defined:
  - The idle counter resets on each accept and counts while `hold_valid & enable`.
  - When it reaches `timeout` (nonzero), it raises `flush` for one cycle (held pending if the FIFO is full).
- Undefined: the `timeout` port exists but is ignored. Partial packets close only on disable.

## Structure
- Package `axis_pkt_pkg`:
  - `fifo_entry_t` struct `{tlast, tdata}`;
  - the `CNT_W = 32` constant;
  - the saturating-increment function.
- Sub-module `axis_pkt_fifo`: a synchronous FIFO of `fifo_entry_t`, with `full`/`empty` from pointers one bit wider than the address, and a registered read.

## Test plan
- Basic framing: `len=4`, 8 continuous beats 0..7, `tready=1`, so two packets; `tlast` on data 3 and 7; `pkt_cnt=2`; `overflow_cnt=0`.
- Overflow: `FIFO_DEPTH=16`, `len=64`, `tready=0`, 20 beats 0..19. Data 0..15 are queued, 16 is held, and 17..19 are dropped, so `overflow_cnt=3`. Releasing `tready` then yields 0..15 in order.
- Disable flush: `len=8`, 5 beats, then `enable=0`. Output is a 5-beat packet with `tlast` on beat 5; `busy` falls after the drain.
- Timeout (with `AXIS_PKT_TIMEOUT_EN`): `len=8`, `timeout=10`, 3 beats then idle. `tlast` is on beat 3, written 10 cycles after the last accept. Without the macro, no `tlast` is emitted.
- Edge length: `len=1` and `len=0` both give `tlast` on every beat. Back-to-back accept during a `hold_last` write loses no data.
- Reset mid-packet: 3 of 8 beats have been sent. On the next edge `tvalid=0`, counters are 0 and `busy=0`. The next packet is a full 8 beats.
